// File: rtl/gpu_cmd_packer_if.sv
// Handshake bundle between the byte source, gpu_cmd_packer and the GPU
// command port. The packer uses the master view and its environment the slave view.
interface gpu_cmd_packer_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          dv;
    logic [31:0]   din;
    logic          ready;
    logic [CW-1:0] fifo_count;
    logic [7:0]    drop_count;
    logic          busy;

    modport master (
        input  in_valid, in_data, ready,
        output in_ready, dv, din, fifo_count, drop_count, busy
    );

    modport slave (
        output in_valid, in_data, ready,
        input  in_ready, dv, din, fifo_count, drop_count, busy
    );
endinterface

// File: rtl/gpu_cmd_packer.sv
// Packs a byte stream big-endian into 32-bit GPU command words, queues them in a
// first-word-fall-through FIFO, and discards partial words that stall too long.
module gpu_cmd_packer #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    gpu_cmd_packer_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TMO_EN = (TIMEOUT > 0);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    logic [1:0]    byte_cnt_r;
    logic [23:0]   shift_r;
    logic [TW-1:0] tmo_cnt_r;
    logic [7:0]    drop_cnt_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [31:0]   mem_r [DEPTH];

    logic        full_s;
    logic        ready_s;
    logic        accept_s;
    logic        push_s;
    logic        pop_s;
    logic        expire_s;
    logic        dv_s;
    logic [31:0] word_s;

    // The fourth byte is only blocked by a full FIFO; a same-cycle pop is ignored
    // so there is no combinational path from the GPU ready to in_ready.
    assign full_s   = (count_r == FULL_LVL);
    assign ready_s  = !((byte_cnt_r == 2'd3) && full_s);
    assign accept_s = bus.in_valid && ready_s;
    assign push_s   = accept_s && (byte_cnt_r == 2'd3);
    assign dv_s     = (count_r != {CW{1'b0}});
    assign pop_s    = dv_s && bus.ready;
    assign word_s   = {shift_r, bus.in_data};

    // An accepted byte in the expiry cycle wins over the discard.
    assign expire_s = TMO_EN && (byte_cnt_r != 2'd0) && !accept_s
                      && (tmo_cnt_r == TMO_LAST);

    // Packing state, stall timer, drop statistics and FIFO pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt_r <= 2'd0;
            shift_r    <= 24'd0;
            tmo_cnt_r  <= {TW{1'b0}};
            drop_cnt_r <= 8'd0;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
        end else begin
            if (accept_s) begin
                byte_cnt_r <= byte_cnt_r + 2'd1;
                shift_r    <= push_s ? 24'd0 : {shift_r[15:0], bus.in_data};
            end else if (expire_s) begin
                byte_cnt_r <= 2'd0;
                shift_r    <= 24'd0;
            end else begin
                byte_cnt_r <= byte_cnt_r;
                shift_r    <= shift_r;
            end

            if (accept_s || expire_s || (byte_cnt_r == 2'd0) || !TMO_EN) begin
                tmo_cnt_r <= {TW{1'b0}};
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end

            if (expire_s && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end

            // Power-of-two depth lets the pointers wrap naturally.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end

            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end

            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Word storage; left unreset because the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= word_s;
        end
    end

    assign bus.in_ready   = ready_s;
    assign bus.dv         = dv_s;
    assign bus.din        = dv_s ? mem_r[rd_ptr_r] : 32'd0;
    assign bus.fifo_count = count_r;
    assign bus.drop_count = drop_cnt_r;
    assign bus.busy       = (byte_cnt_r != 2'd0) || dv_s;
endmodule

// File: tb/tb_gpu_cmd_packer.sv
// Scoreboard bench for gpu_cmd_packer: completed words are queued as they are
// driven and compared against din whenever the GPU side accepts a word.
module tb_gpu_cmd_packer;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] exp_q [$];
    logic [7:0]  part_q [$];

    always #5 clk = ~clk;

    gpu_cmd_packer_if #(.DEPTH(DEPTH)) bus ();

    gpu_cmd_packer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bench-side packing: every fourth accepted byte completes an expected word.
    task automatic note_byte(input logic [7:0] b);
        part_q.push_back(b);
        if (part_q.size() == 4) begin
            exp_q.push_back({part_q[0], part_q[1], part_q[2], part_q[3]});
            part_q.delete();
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
        end
        bus.in_valid = 1'b0;
        check_val("send_accept", {31'd0, acc}, 32'd1);
        if (acc) note_byte(b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.ready = 1'b1;
        while (bus.fifo_count != '0 && n < 100) begin
            step();
            n++;
        end
        check_val("drain_done", 32'(bus.fifo_count), 32'd0);
    endtask

    // Output side of the scoreboard: a word leaves at the edge following dv && ready.
    always @(negedge clk) begin
        if (rst_n && bus.dv && bus.ready) begin
            check_val("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check_val("word", bus.din, exp_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b4;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        bus.ready    = 1'b0;

        // Reset values
        rst_n = 1'b0;
        repeat (3) step();
        check_val("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_val("rst_dv", {31'd0, bus.dv}, 32'd0);
        check_val("rst_din", bus.din, 32'd0);
        check_val("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
        check_val("rst_drop_count", 32'(bus.drop_count), 32'd0);
        check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;

        // Single word with the GPU ready
        bus.ready = 1'b1;
        send(8'hDE);
        send(8'hAD);
        send(8'hBE);
        check_val("t1_dv_before", {31'd0, bus.dv}, 32'd0);
        send(8'hEF);
        check_val("t1_dv", {31'd0, bus.dv}, 32'd1);
        check_val("t1_din", bus.din, 32'hDEADBEEF);
        step();
        check_val("t1_dv_fall", {31'd0, bus.dv}, 32'd0);
        check_val("t1_count", 32'(bus.fifo_count), 32'd0);
        check_val("t1_busy", {31'd0, bus.busy}, 32'd0);

        // Fill the FIFO with the GPU stalled, then block the fourth byte
        bus.ready = 1'b0;
        for (int i = 0; i < 4 * DEPTH; i++) send(8'(i * 7 + 3));
        check_val("t2_full_count", 32'(bus.fifo_count), 32'd16);
        check_val("t2_in_ready_cnt0", {31'd0, bus.in_ready}, 32'd1);
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        b4 = 8'hA4;
        bus.in_valid = 1'b1;
        bus.in_data  = b4;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("t2_blocked", {31'd0, bus.in_ready}, 32'd0);
            step();
        end
        check_val("t2_held_count", 32'(bus.fifo_count), 32'd16);
        // One-cycle ready pulse while the fourth byte is presented
        bus.ready = 1'b1;
        @(negedge clk);
        check_val("t3_blocked_same_cycle", {31'd0, bus.in_ready}, 32'd0);
        step();
        bus.ready = 1'b0;
        check_val("t3_count_after_pop", 32'(bus.fifo_count), 32'd15);
        @(negedge clk);
        check_val("t3_in_ready_after_pop", {31'd0, bus.in_ready}, 32'd1);
        step();
        note_byte(b4);
        bus.in_valid = 1'b0;
        check_val("t3_count_refill", 32'(bus.fifo_count), 32'd16);
        drain();
        check_val("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Timeout discards a two-byte partial word
        send(8'h11);
        send(8'h22);
        repeat (7) step();
        check_val("t4_no_drop_yet", 32'(bus.drop_count), 32'd0);
        check_val("t4_busy_partial", {31'd0, bus.busy}, 32'd1);
        step();
        part_q.delete();
        check_val("t4_drop", 32'(bus.drop_count), 32'd1);
        check_val("t4_busy_after_drop", {31'd0, bus.busy}, 32'd0);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        send(8'hDD);
        check_val("t4_din", bus.din, 32'hAABBCCDD);
        step();

        // A byte in the expiry cycle wins
        send(8'h33);
        repeat (7) step();
        send(8'h44);
        check_val("t5_no_drop", 32'(bus.drop_count), 32'd1);
        send(8'h55);
        send(8'h66);
        check_val("t5_din", bus.din, 32'h33445566);
        step();

        // Saturating drop counter
        for (int k = 1; k <= 300; k++) begin
            send(8'(k));
            repeat (TIMEOUT) step();
            part_q.delete();
            if (k == 10) check_val("t5_drop_11", 32'(bus.drop_count), 32'd11);
        end
        check_val("t5_drop_sat", 32'(bus.drop_count), 32'd255);

        // Reset mid-word with words queued
        bus.ready = 1'b0;
        for (int i = 0; i < 14; i++) send(8'(8'h80 + i));
        check_val("t6_queued", 32'(bus.fifo_count), 32'd3);
        rst_n = 1'b0;
        step();
        check_val("t6_dv", {31'd0, bus.dv}, 32'd0);
        check_val("t6_count", 32'(bus.fifo_count), 32'd0);
        check_val("t6_drop", 32'(bus.drop_count), 32'd0);
        check_val("t6_busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        part_q.delete();
        bus.ready = 1'b1;
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        check_val("t6_din", bus.din, 32'h01020304);
        repeat (3) step();
        check_val("t6_fifo_empty", 32'(bus.fifo_count), 32'd0);
        check_val("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
